io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_FC00, the base of the peripheral window; the window is BASE_ADDR..BASE_ADDR+0x3F.
REQ-002 SHALL have ports, in this order:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- io_addr  input  32  byte address from the CPU-side decoder.
- io_we  input  1  write strobe, sampled at the rising edge of clk.
- io_wdata  input  32  write data.
- io_rdata  output  32  read data, combinational from io_addr.
- sw  input  16  board switches, asynchronous to clk.
- led  output  16  board LEDs.
- irq  output  1  timer interrupt, level.
REQ-003 One clock, clk; reset is asynchronous and active-low, rst_n.

Function
REQ-004 The register map SHALL be, by byte offset io_addr - BASE_ADDR, with io_addr[1:0] ignored:
- 0x00 LED, RW; bits [15:0] drive led, upper bits read 0.
- 0x04 SW, RO; synchronized switches in bits [15:0].
- 0x08 CTRL, RW; bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable).
- 0x0C LOAD, RW, 32-bit.
- 0x10 COUNT, RO, 32-bit.
- 0x14 STATUS; bit0 EXP; writing 1 to bit0 clears it, writing 0 has no effect.
REQ-005 A write SHALL take effect at the clk edge when io_we=1 and the address is in-window.
REQ-006 Writes to RO offsets, to unmapped offsets (0x18..0x3C), or to any out-of-window address SHALL be ignored.
REQ-007 io_rdata SHALL return the addressed register in the same cycle, with zero wait states. Unmapped or out-of-window reads SHALL return 32'h0.
REQ-008 sw SHALL pass through a 2-flop synchronizer. The SW read value therefore lags a pin change by 2-3 cycles.
REQ-009 The timer FSM SHALL have states IDLE, RUN and DONE.
REQ-010 IDLE -> RUN occurs on the edge where CTRL is written with EN=1: COUNT<=LOAD in that same edge.
REQ-011 In RUN, each edge with COUNT!=0 SHALL decrement COUNT by 1.
REQ-012 In RUN, on the edge with COUNT==0, EXP<=1. Then:
- If AUTO=1: COUNT<=LOAD and the FSM stays in RUN.
- If AUTO=0: the FSM goes to DONE and the CTRL EN bit clears to 0.
REQ-013 The expiry period SHALL therefore be LOAD+1 cycles. LOAD=0 with AUTO=1 SHALL expire every cycle.
REQ-014 Writing CTRL with EN=0 in RUN or DONE SHALL go to IDLE; COUNT holds its value.
REQ-015 Writing CTRL with EN=1 while in RUN SHALL restart: COUNT<=LOAD.
REQ-016 DONE -> RUN SHALL occur on a CTRL write with EN=1, reloading COUNT.
REQ-017 A LOAD write during RUN SHALL NOT affect COUNT until the next reload.
REQ-018 If expiry and a STATUS write-1-clear occur on the same edge, set SHALL win: EXP=1.
REQ-019 COUNT SHALL wrap-protect: it never decrements below 0.
REQ-020 irq SHALL equal EXP & IE, combinational from registers.
REQ-021 Reads SHALL have no side effects.

Reset
REQ-022 When rst_n=0, the block SHALL immediately, asynchronously, set:
- LED=0, so led=16'h0.
- CTRL=0, LOAD=0, COUNT=0.
- EXP=0, so irq=0.
- Synchronizer flops = 0.
- FSM = IDLE.
REQ-023 Reset asserted mid-RUN SHALL abort the count. No expiry or irq SHALL occur after release until the timer is re-enabled.
REQ-024 After deassertion, the first write SHALL be accepted on the first clk edge.

Verification
REQ-025 LED write/read: write 0x00 with 32'hABCD_1234 -> led=16'h1234 after the edge; read 0x00 = 32'h0000_1234. Then write BASE_ADDR+0x40 with 0xFFFF -> led unchanged, read returns 0.
REQ-026 Switch sync: sw 0->16'h00F0 -> SW read = 0 for 2 edges, then 32'h0000_00F0 by the 3rd edge.
REQ-027 One-shot: LOAD=3; CTRL=3'b101 -> EXP and irq rise exactly 4 edges after the CTRL write; FSM in DONE; CTRL reads 3'b100; COUNT=0.
REQ-028 Auto-reload: LOAD=2; CTRL=3'b011 -> EXP sets every 3 cycles. Write STATUS=1 on a non-expiry edge -> EXP=0. Write STATUS=1 on an expiry edge -> EXP stays 1.
REQ-029 Stop and restart: LOAD=10; enable; after 4 edges write CTRL=0 -> COUNT holds 6. Write CTRL=1 -> COUNT=10 on the next edge.
REQ-030 Reset mid-RUN: assert rst_n=0 between clock edges -> all outputs 0 immediately. After release, with no enable, irq stays 0 for ≥20 cycles.

Source files
------------

// File: rtl/io_responder.sv
// io_responder
//
// Memory-mapped peripheral responder for a 64-byte window starting at
// BASE_ADDR. It provides an LED output register, a synchronized switch
// input register, and a down-counting timer. The timer has one-shot and
// auto-reload modes and a level interrupt.
//
// Register map (byte offset from BASE_ADDR, io_addr[1:0] ignored):
//   0x00 LED    RW  bits [15:0] drive led
//   0x04 SW     RO  synchronized switches in bits [15:0]
//   0x08 CTRL   RW  bit0 EN, bit1 AUTO, bit2 IE
//   0x0C LOAD   RW  reload value
//   0x10 COUNT  RO  current timer value
//   0x14 STATUS W1C bit0 EXP
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   io_addr   byte address from the CPU-side decoder
//   io_we     write strobe, sampled at the rising edge
//   io_wdata  write data
//   io_rdata  read data, combinational from io_addr
//   sw        board switches (asynchronous to clk)
//   led       board LEDs
//   irq       timer interrupt, level (EXP & IE)
module io_responder #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FC00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_addr,
    input  logic        io_we,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] led_q, led_d;
    logic [15:0] sw_meta_q, sw_meta_d;
    logic [15:0] sw_sync_q, sw_sync_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        exp_q, exp_d;

    logic [31:0] offset;
    logic        in_window;
    logic [3:0]  reg_sel;
    logic        wr_led, wr_ctrl, wr_load, wr_status;
    logic        expire;

    // The subtraction wraps, so addresses below BASE_ADDR land far above
    // 0x3F and fall out of the window.
    assign offset    = io_addr - BASE_ADDR;
    assign in_window = (offset < 32'h0000_0040);
    assign reg_sel   = offset[5:2];

    assign wr_led    = io_we && in_window && (reg_sel == 4'h0);
    assign wr_ctrl   = io_we && in_window && (reg_sel == 4'h2);
    assign wr_load   = io_we && in_window && (reg_sel == 4'h3);
    assign wr_status = io_we && in_window && (reg_sel == 4'h5);

    assign led = led_q;
    assign irq = exp_q & ctrl_q[2];

    // Zero-wait-state read mux. Reads have no side effects.
    always_comb begin
        io_rdata = 32'h0;
        if (in_window) begin
            case (reg_sel)
                4'h0:    io_rdata = {16'h0, led_q};
                4'h1:    io_rdata = {16'h0, sw_sync_q};
                4'h2:    io_rdata = {29'h0, ctrl_q};
                4'h3:    io_rdata = load_q;
                4'h4:    io_rdata = count_q;
                4'h5:    io_rdata = {31'h0, exp_q};
                default: io_rdata = 32'h0;
            endcase
        end
    end

    // Next-state logic for registers and the timer FSM. Priority order:
    // the timer runs first, then an expiry sets EXP over any same-edge
    // clear, and a CTRL write finally overrides the timer's state/count
    // (enable restarts from LOAD, disable freezes COUNT where it is).
    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
        ctrl_d    = ctrl_q;
        load_d    = load_q;
        count_d   = count_q;
        exp_d     = exp_q;
        expire    = 1'b0;

        if (wr_led) begin
            led_d = io_wdata[15:0];
        end
        if (wr_load) begin
            load_d = io_wdata;
        end
        if (wr_status && io_wdata[0]) begin
            exp_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (count_q != 32'h0) begin
                    count_d = count_q - 32'h1;
                end else begin
                    expire = 1'b1;
                    if (ctrl_q[1]) begin
                        count_d = load_q;
                    end else begin
                        state_d   = DONE;
                        ctrl_d[0] = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase

        if (expire) begin
            exp_d = 1'b1;
        end

        if (wr_ctrl) begin
            ctrl_d = io_wdata[2:0];
            if (io_wdata[0]) begin
                state_d = RUN;
                count_d = load_q;
            end else begin
                state_d = IDLE;
                count_d = count_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            led_q     <= 16'h0;
            sw_meta_q <= 16'h0;
            sw_sync_q <= 16'h0;
            ctrl_q    <= 3'h0;
            load_q    <= 32'h0;
            count_q   <= 32'h0;
            exp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            exp_q     <= exp_d;
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder
//
// Directed testbench for io_responder. Each scenario task drives its own
// stimulus and compares observed values against hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns after the
// rising edge or between edges.
`timescale 1ns/100ps

module tb_io_responder;

    localparam logic [31:0] BASE = 32'hFFFF_FC00;
    localparam logic [31:0] OFF_LED    = 32'h00;
    localparam logic [31:0] OFF_SW     = 32'h04;
    localparam logic [31:0] OFF_CTRL   = 32'h08;
    localparam logic [31:0] OFF_LOAD   = 32'h0C;
    localparam logic [31:0] OFF_COUNT  = 32'h10;
    localparam logic [31:0] OFF_STATUS = 32'h14;

    logic        clk;
    logic        rst_n;
    logic [31:0] io_addr;
    logic        io_we;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic [15:0] sw;
    logic [15:0] led;
    logic        irq;

    int          assert_count;
    int          fail_count;
    logic [31:0] rd;

    io_responder #(.BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_addr  (io_addr),
        .io_we    (io_we),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .sw       (sw),
        .led      (led),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One register write: set up on the falling edge, commit on the rising
    // edge, then drop the strobe 1ns later.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        io_addr  = addr;
        io_wdata = data;
        io_we    = 1'b1;
        @(posedge clk);
        #1;
        io_we    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
        io_addr = addr;
        #0.2;
        data = io_rdata;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        io_addr = BASE;
        io_we = 1'b0;
        io_wdata = 32'h0;
        sw = 16'h0;
        #12;
        assert_count++;
        if (led !== 16'h0) begin
            fail_count++;
            $display("[TB] FAIL reset_led: got %h expected %h", led, 16'h0);
        end
        assert_count++;
        if (irq !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        end
        read_reg(BASE + OFF_CTRL, rd);
        assert_count++;
        if (rd !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL reset_ctrl: got %h expected 0", rd);
        end
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL reset_count: got %h expected 0", rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_led();
        do_write(BASE + OFF_LED, 32'hABCD_1234);
        assert_count++;
        if (led !== 16'h1234) begin
            fail_count++;
            $display("[TB] FAIL led_write: got %h expected 1234", led);
        end
        read_reg(BASE + OFF_LED, rd);
        assert_count++;
        if (rd !== 32'h0000_1234) begin
            fail_count++;
            $display("[TB] FAIL led_read: got %h expected 00001234", rd);
        end
        do_write(BASE + 32'h40, 32'h0000_FFFF);
        assert_count++;
        if (led !== 16'h1234) begin
            fail_count++;
            $display("[TB] FAIL led_out_of_window: got %h expected 1234", led);
        end
        read_reg(BASE + 32'h40, rd);
        assert_count++;
        if (rd !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL read_out_of_window: got %h expected 0", rd);
        end
        do_write(BASE - 32'h4, 32'h0000_5555);
        assert_count++;
        if (led !== 16'h1234) begin
            fail_count++;
            $display("[TB] FAIL led_below_window: got %h expected 1234", led);
        end
        do_write(BASE + 32'h18, 32'h0000_7777);
        read_reg(BASE + 32'h18, rd);
        assert_count++;
        if (rd !== 32'h0 || led !== 16'h1234) begin
            fail_count++;
            $display("[TB] FAIL unmapped: got rd=%h led=%h expected 0/1234", rd, led);
        end
    endtask

    task automatic test_sw_sync();
        @(negedge clk);
        sw = 16'h00F0;
        tick();
        read_reg(BASE + OFF_SW, rd);
        assert_count++;
        if (rd !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL sw_edge1: got %h expected 0", rd);
        end
        tick();
        tick();
        read_reg(BASE + OFF_SW, rd);
        assert_count++;
        if (rd !== 32'h0000_00F0) begin
            fail_count++;
            $display("[TB] FAIL sw_edge3: got %h expected 000000f0", rd);
        end
        do_write(BASE + OFF_SW, 32'h0000_0000);
        read_reg(BASE + OFF_SW, rd);
        assert_count++;
        if (rd !== 32'h0000_00F0) begin
            fail_count++;
            $display("[TB] FAIL sw_ro: got %h expected 000000f0", rd);
        end
    endtask

    task automatic test_one_shot();
        do_write(BASE + OFF_LOAD, 32'd3);
        do_write(BASE + OFF_CTRL, 32'h5);
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'd3) begin
            fail_count++;
            $display("[TB] FAIL oneshot_start_count: got %0d expected 3", rd);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            read_reg(BASE + OFF_STATUS, rd);
            assert_count++;
            if (rd !== 32'h0 || irq !== 1'b0) begin
                fail_count++;
                $display("[TB] FAIL oneshot_early_edge%0d: got exp=%h irq=%b expected 0/0", i, rd, irq);
            end
        end
        tick();
        assert_count++;
        if (irq !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL oneshot_irq: got %b expected 1", irq);
        end
        read_reg(BASE + OFF_CTRL, rd);
        assert_count++;
        if (rd !== 32'h4) begin
            fail_count++;
            $display("[TB] FAIL oneshot_ctrl: got %h expected 4", rd);
        end
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL oneshot_count: got %h expected 0", rd);
        end
        tick();
        tick();
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'h0 || irq !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL done_hold: got count=%h irq=%b expected 0/1", rd, irq);
        end
        do_write(BASE + OFF_STATUS, 32'h0);
        assert_count++;
        if (irq !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL status_write0: got irq=%b expected 1", irq);
        end
        do_write(BASE + OFF_STATUS, 32'h1);
        assert_count++;
        if (irq !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL status_clear: got irq=%b expected 0", irq);
        end
    endtask

    task automatic test_auto_reload();
        do_write(BASE + OFF_LOAD, 32'd2);
        do_write(BASE + OFF_CTRL, 32'h3);
        for (int i = 1; i <= 2; i++) begin
            tick();
            read_reg(BASE + OFF_STATUS, rd);
            assert_count++;
            if (rd !== 32'h0) begin
                fail_count++;
                $display("[TB] FAIL auto_early_edge%0d: got exp=%h expected 0", i, rd);
            end
        end
        tick();
        read_reg(BASE + OFF_STATUS, rd);
        assert_count++;
        if (rd !== 32'h1 || irq !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL auto_expire: got exp=%h irq=%b expected 1/0", rd, irq);
        end
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'd2) begin
            fail_count++;
            $display("[TB] FAIL auto_reload_count: got %0d expected 2", rd);
        end
        do_write(BASE + OFF_STATUS, 32'h1);
        read_reg(BASE + OFF_STATUS, rd);
        assert_count++;
        if (rd !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL auto_clear_nonexpiry: got %h expected 0", rd);
        end
        tick();
        do_write(BASE + OFF_STATUS, 32'h1);
        read_reg(BASE + OFF_STATUS, rd);
        assert_count++;
        if (rd !== 32'h1) begin
            fail_count++;
            $display("[TB] FAIL auto_set_wins: got %h expected 1", rd);
        end
        do_write(BASE + OFF_LOAD, 32'd7);
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'd1) begin
            fail_count++;
            $display("[TB] FAIL load_during_run: got %0d expected 1", rd);
        end
        tick();
        tick();
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'd7) begin
            fail_count++;
            $display("[TB] FAIL load_next_reload: got %0d expected 7", rd);
        end
        do_write(BASE + OFF_CTRL, 32'h0);
        do_write(BASE + OFF_STATUS, 32'h1);
    endtask

    task automatic test_load_zero_auto();
        do_write(BASE + OFF_LOAD, 32'd0);
        do_write(BASE + OFF_CTRL, 32'h3);
        for (int i = 1; i <= 3; i++) begin
            do_write(BASE + OFF_STATUS, 32'h1);
            read_reg(BASE + OFF_STATUS, rd);
            assert_count++;
            if (rd !== 32'h1) begin
                fail_count++;
                $display("[TB] FAIL load0_every_cycle_%0d: got %h expected 1", i, rd);
            end
        end
        do_write(BASE + OFF_CTRL, 32'h0);
        do_write(BASE + OFF_STATUS, 32'h1);
        read_reg(BASE + OFF_STATUS, rd);
        assert_count++;
        if (rd !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL load0_stopped: got %h expected 0", rd);
        end
    endtask

    task automatic test_stop_restart();
        do_write(BASE + OFF_LOAD, 32'd10);
        do_write(BASE + OFF_CTRL, 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'd6) begin
            fail_count++;
            $display("[TB] FAIL run_4_edges: got %0d expected 6", rd);
        end
        do_write(BASE + OFF_CTRL, 32'h0);
        tick();
        tick();
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'd6) begin
            fail_count++;
            $display("[TB] FAIL stop_hold: got %0d expected 6", rd);
        end
        do_write(BASE + OFF_CTRL, 32'h1);
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'd10) begin
            fail_count++;
            $display("[TB] FAIL restart_reload: got %0d expected 10", rd);
        end
        tick();
        tick();
        do_write(BASE + OFF_CTRL, 32'h1);
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'd10) begin
            fail_count++;
            $display("[TB] FAIL run_restart: got %0d expected 10", rd);
        end
        do_write(BASE + OFF_CTRL, 32'h0);
    endtask

    task automatic test_reset_mid_run();
        do_write(BASE + OFF_LOAD, 32'd1);
        do_write(BASE + OFF_CTRL, 32'h7);
        tick();
        tick();
        assert_count++;
        if (irq !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL pre_reset_irq: got %b expected 1", irq);
        end
        #2;
        rst_n = 1'b0;
        #1;
        assert_count++;
        if (irq !== 1'b0 || led !== 16'h0) begin
            fail_count++;
            $display("[TB] FAIL async_reset_outputs: got irq=%b led=%h expected 0/0000", irq, led);
        end
        read_reg(BASE + OFF_COUNT, rd);
        assert_count++;
        if (rd !== 32'h0) begin
            fail_count++;
            $display("[TB] FAIL async_reset_count: got %h expected 0", rd);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        io_addr  = BASE + OFF_LED;
        io_wdata = 32'h0000_55AA;
        io_we    = 1'b1;
        @(posedge clk);
        #1;
        io_we = 1'b0;
        assert_count++;
        if (led !== 16'h55AA) begin
            fail_count++;
            $display("[TB] FAIL first_write_after_reset: got %h expected 55aa", led);
        end
        for (int i = 0; i < 22; i++) begin
            tick();
            assert_count++;
            if (irq !== 1'b0) begin
                fail_count++;
                $display("[TB] FAIL post_reset_irq_cycle%0d: got %b expected 0", i, irq);
            end
        end
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        test_reset();
        test_led();
        test_sw_sync();
        test_one_shot();
        test_auto_reload();
        test_load_zero_auto();
        test_stop_restart();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
